stream_serializer: RTL
======================

# stream_serializer

Width down-converter for valid/ready streams. Accepts one wide word of `DN_WIDTH*RATIO` bits per upstream transaction and emits it as `RATIO` consecutive narrow beats, with a last-beat flag. It sits directly downstream of the skid register and consumes its `dn_*` stream. Its combinational `up_rdy` is safe because the skid register registers its own upstream ready.

## Interface
- `DN_WIDTH`, 8: narrow output beat width in bits.
- `RATIO`, 4: beats per wide word; must be ≥ 1; up width is `DN_WIDTH*RATIO`.
- `MSB_FIRST`, 0: 0 emits slice [DN_WIDTH-1:0] first; 1 emits the top slice first.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `up_bus`, in, DN_WIDTH*RATIO: wide input word.
- `up_val`, in, 1: `up_bus` valid.
- `up_rdy`, out, 1: block accepts `up_bus` this cycle; combinational.
- `dn_bus`, out, DN_WIDTH: current narrow beat; registered.
- `dn_val`, out, 1: `dn_bus` valid; registered.
- `dn_last`, out, 1: current beat is the final slice of its word; registered.
- `dn_rdy`, in, 1: downstream accepts beat.

## Operation
- State:
  - word holding register `hold` (DN_WIDTH*RATIO bits);
  - beat counter `cnt`, width max(1, clog2(RATIO)), range 0..RATIO-1;
  - `dn_val` acts as the EMPTY/SEND state bit.
- `up_rdy = ~rst & (~dn_val | (dn_rdy & dn_last))`.
- Accept (`up_val & up_rdy`):
  - `hold <= up_bus`; `cnt <= 0`; `dn_val <= 1`;
  - `dn_bus <=` first slice (per MSB_FIRST);
  - `dn_last <= (RATIO == 1)`.
- Advance (`dn_val & dn_rdy & ~dn_last`):
  - `cnt <= cnt + 1`;
  - `dn_bus <=` slice `cnt+1` of `hold`;
  - `dn_last <= (cnt+1 == RATIO-1)`.
- Final beat taken (`dn_val & dn_rdy & dn_last`):
  - if `up_val`, this is an accept (the accept rule applies, no bubble);
  - else `dn_val <= 0`, `dn_last <= 0`.
- Stall (`dn_val & ~dn_rdy`): `dn_bus`, `dn_last`, `cnt` and `hold` hold their values.
- Slice arithmetic:
  - LSB-first slice k = `hold[k*DN_WIDTH +: DN_WIDTH]`;
  - MSB-first slice k = index `RATIO-1-k`.
- Counter never wraps past RATIO-1; it is reloaded to 0 only on accept.
- `RATIO == 1`: behaves as a one-deep registered pipeline stage, with `dn_last` permanently 1 while `dn_val` is high.

## Timing
- Reset values:
  - `dn_val` = 0, `dn_last` = 0, `cnt` = 0;
  - `up_rdy` = 0 while `rst` is high, and 1 the first cycle after;
  - `dn_bus` and `hold` are don't-care (not reset).
- Latency: first beat is presented on `dn_bus` the cycle after the upstream accept.
- Throughput: one beat per cycle when `dn_rdy` is held high. Upstream words are accepted every RATIO cycles, back-to-back with no idle cycle.
- Handshake rules:
  - once `dn_val` is high it stays high until a beat is taken;
  - `dn_bus` and `dn_last` are stable while stalled;
  - `dn_val` falls only in the cycle after `dn_val & dn_rdy & dn_last`.
- Reset mid-word discards the remaining beats. The next word starts at slice 0.
- Simultaneous final-beat take and new upstream word: both complete in the same cycle (accept wins over empty).

## Structure
- The `clog2` helper function and the counter-width expression belong in the shared stream include, common with the other stream blocks.
- No sub-module is needed. The top level chains `skid_register` → `stream_serializer`.

## Test plan
All cases use `DN_WIDTH`=8, `RATIO`=4, `MSB_FIRST`=0 unless stated.
- **Reset:** hold `rst` 3 cycles with `up_val`=1 → `dn_val`=0, `dn_last`=0, `up_rdy`=0 throughout; `up_rdy`=1 on the first cycle after reset.
- **Single word:** word 0x44332211 with `dn_rdy`=1 → beats 0x11, 0x22, 0x33, 0x44 on cycles 1–4; `dn_last` only with 0x44; `up_rdy`=0 on cycles 1–3 and 1 on cycle 4.
- **Back-to-back words:** 0x44332211 then 0x88776655, `up_val` held, `dn_rdy`=1 → 8 consecutive beats 0x11..0x88 with no gap; second word accepted on cycle 4.
- **Backpressure:** drop `dn_rdy` for 3 cycles while 0x22 is presented → `dn_bus`=0x22 and `dn_val`=1 held, `up_rdy`=0; 0x33 appears the cycle after `dn_rdy` returns.
- **MSB-first:** `MSB_FIRST`=1, word 0x44332211 → beats 0x44, 0x33, 0x22, 0x11, with `dn_last` on 0x11.
- **Reset mid-word and RATIO=1:**
  - assert `rst` after 2 beats → `dn_val`=0 the next cycle; word 0xDDCCBBAA sent after reset yields 0xAA first;
  - `RATIO`=1 variant: each word appears one cycle later with `dn_last`=1.

Source files
------------

// File: rtl/stream_serializer_pkg.sv
// Shared stream helpers: width arithmetic used by the stream blocks.
package stream_serializer_pkg;

    // Ceiling log2. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    // Beat counter width: at least one bit, so RATIO == 1 still has a legal vector.
    function automatic int cnt_width(input int ratio);
        int w;
        w = clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Width down-converter: one wide word in, RATIO narrow beats out, with dn_last
// marking the final slice. dn_val doubles as the EMPTY/SEND state bit.
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int DN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DN_WIDTH*RATIO-1:0] up_bus,
    input  logic                      up_val,
    output logic                      up_rdy,
    output logic [DN_WIDTH-1:0]       dn_bus,
    output logic                      dn_val,
    output logic                      dn_last,
    input  logic                      dn_rdy
);

    localparam int UP_W  = DN_WIDTH * RATIO;
    localparam int CNT_W = cnt_width(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [UP_W-1:0]  hold;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;
    logic             val_nxt;
    logic             last_nxt;
    logic             accept;
    logic             advance;
    logic             final_take;

    // Select beat k of a word; MSB-first walks the slices from the top down.
    // The loop keeps every part-select constant.
    function automatic logic [DN_WIDTH-1:0] slice(input logic [UP_W-1:0] w,
                                                  input logic [CNT_W-1:0] k);
        logic [DN_WIDTH-1:0] s;
        int idx;
        s   = '0;
        idx = MSB_FIRST ? (RATIO - 1 - int'(k)) : int'(k);
        for (int i = 0; i < RATIO; i++) begin
            if (i == idx) begin
                s = w[i*DN_WIDTH +: DN_WIDTH];
            end
        end
        return s;
    endfunction

    // A new word may enter when empty, or when the final beat leaves this cycle.
    assign up_rdy     = ~rst & (~dn_val | (dn_rdy & dn_last));
    assign accept     = up_val & up_rdy;
    assign advance    = dn_val & dn_rdy & ~dn_last;
    assign final_take = dn_val & dn_rdy & dn_last;
    assign cnt_inc    = cnt + CNT_W'(1);

    // Next-state for the control bits; accept takes priority over emptying.
    always_comb begin
        val_nxt  = dn_val;
        last_nxt = dn_last;
        cnt_nxt  = cnt;
        if (accept) begin
            val_nxt  = 1'b1;
            last_nxt = (RATIO == 1);
            cnt_nxt  = '0;
        end else if (advance) begin
            cnt_nxt  = cnt_inc;
            last_nxt = (cnt_inc == CNT_LAST);
        end else if (final_take) begin
            val_nxt  = 1'b0;
            last_nxt = 1'b0;
        end
    end

    // Control state register: only these bits see reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_val  <= 1'b0;
            dn_last <= 1'b0;
            cnt     <= '0;
        end else begin
            dn_val  <= val_nxt;
            dn_last <= last_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Data path: capture the word on accept, step to the next slice on advance,
    // otherwise hold (covers stall).
    always_ff @(posedge clk) begin
        if (accept) begin
            hold   <= up_bus;
            dn_bus <= slice(up_bus, '0);
        end else if (advance) begin
            dn_bus <= slice(hold, cnt_inc);
        end
    end

endmodule
